// File: rtl/npu_bram_pkg.sv
// ----------------------------------------------------------------------------
// npu_bram_pkg
//  Shared types and default sizes for the NPU frame BRAM controller.
//  Contents:
//    state_t          controller FSM state (IDLE / LOAD / FULL / READ)
//    DEF_ADDR_WIDTH   default BRAM address width
//    DEF_WEIGHT_WIDTH default data word width
//    DEF_FRAME_LEN    default words per frame (28x28)
// ----------------------------------------------------------------------------
package npu_bram_pkg;

    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_FRAME_LEN    = 784;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_READ = 2'd3
    } state_t;

endpackage

// File: rtl/bram_frame_ctrl_out_stage.sv
// ----------------------------------------------------------------------------
// bram_out_stage
//  One-entry valid/ready output register placed after the async-read BRAM.
//  Ports:
//    i_clk, i_rst   clock, synchronous active-high reset (empties the stage)
//    load           capture in_data/in_last this cycle
//    in_data        word from the BRAM read port
//    in_last        word is the final word of the frame
//    out_ready      downstream accepts out_data
//    out_valid      stage holds a word
//    out_data       held word
//    out_last       held word is the final word (gated by out_valid)
// ----------------------------------------------------------------------------
module bram_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    logic             valid_reg;
    logic             last_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            last_reg  <= in_last;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Data needs no reset: it is only observed while valid_reg is set.
    always_ff @(posedge i_clk) begin
        if (load) begin
            data_reg <= in_data;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    // A stale last flag must not leak out once the final word is consumed.
    assign out_last  = valid_reg & last_reg;

endmodule

// File: rtl/bram_frame_ctrl.sv
// ----------------------------------------------------------------------------
// bram_frame_ctrl
//  Loads one frame from an upstream valid/ready stream into an async-read
//  frame BRAM, then replays it (any number of times) as a valid/ready stream.
//  Optional macro BRAM_RD_REG_EN: adds a one-entry registered output stage
//  (bram_out_stage) fed by a prefetch pointer; otherwise m_data is
//  combinational from the BRAM read port.
//  Ports:
//    i_clk, i_rst        clock, synchronous active-high reset
//    load_start          begin loading a frame at address 0
//    rd_start            begin replaying the stored frame from address 0
//    s_valid/s_data/s_ready          upstream stream
//    m_valid/m_data/m_last/m_ready   downstream stream
//    frame_loaded        complete frame resident
//    busy                LOAD or READ in progress
//    cmd_err             sticky illegal-command flag
//    bram_wr_en/addr/data, bram_rd_addr, bram_rd_data   BRAM port
// ----------------------------------------------------------------------------
module bram_frame_ctrl
    import npu_bram_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
    parameter int FRAME_LEN       = DEF_FRAME_LEN
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       load_start,
    input  logic                       rd_start,
    input  logic                       s_valid,
    input  logic [WEIGHT_WIDTH-1:0]    s_data,
    output logic                       s_ready,
    output logic                       m_valid,
    output logic [WEIGHT_WIDTH-1:0]    m_data,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic                       frame_loaded,
    output logic                       busy,
    output logic                       cmd_err,
    output logic                       bram_wr_en,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [WEIGHT_WIDTH-1:0]    bram_wr_data,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [WEIGHT_WIDTH-1:0]    bram_rd_data
);

    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = BRAM_ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ONE       = BRAM_ADDR_WIDTH'(1);

    state_t                     state_reg, state_next;
    logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [BRAM_ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic                       frame_loaded_reg, frame_loaded_next;
    logic                       cmd_err_reg, cmd_err_next;

    logic accept;
    logic handshake;
    logic rd_last;

    assign accept    = (state_reg == ST_LOAD) && s_valid;
    assign handshake = m_valid && m_ready;
    // rd_ptr counts consumed words, so it marks the final handshake in both builds.
    assign rd_last   = (rd_ptr_reg == LAST_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            frame_loaded_reg <= 1'b0;
            cmd_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            frame_loaded_reg <= frame_loaded_next;
            cmd_err_reg      <= cmd_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        frame_loaded_next = frame_loaded_reg;
        cmd_err_next      = cmd_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next        = ST_LOAD;
                    wr_ptr_next       = '0;
                    frame_loaded_next = 1'b0;
                end else if (rd_start) begin
                    cmd_err_next = 1'b1;
                end
            end
            ST_LOAD: begin
                if (rd_start) begin
                    cmd_err_next = 1'b1;
                end
                if (load_start) begin
                    wr_ptr_next = '0;
                end else if (accept) begin
                    if (wr_ptr_reg == LAST_ADDR) begin
                        state_next        = ST_FULL;
                        frame_loaded_next = 1'b1;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + ONE;
                    end
                end
            end
            ST_FULL: begin
                // load_start outranks rd_start; the collision is not an error.
                if (load_start) begin
                    state_next        = ST_LOAD;
                    wr_ptr_next       = '0;
                    frame_loaded_next = 1'b0;
                end else if (rd_start) begin
                    state_next  = ST_READ;
                    rd_ptr_next = '0;
                end
            end
            ST_READ: begin
                if (load_start || rd_start) begin
                    cmd_err_next = 1'b1;
                end
                if (handshake) begin
                    if (rd_last) begin
                        state_next = ST_FULL;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + ONE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign s_ready      = (state_reg == ST_LOAD);
    assign bram_wr_en   = accept;
    assign bram_wr_addr = wr_ptr_reg;
    assign bram_wr_data = s_data;
    assign busy         = (state_reg == ST_LOAD) || (state_reg == ST_READ);
    assign frame_loaded = frame_loaded_reg;
    assign cmd_err      = cmd_err_reg;

`ifdef BRAM_RD_REG_EN
    // Prefetch pointer runs ahead of rd_ptr by the one word held in the stage.
    logic [BRAM_ADDR_WIDTH-1:0] pf_ptr_reg, pf_ptr_next;
    logic                       pf_active_reg, pf_active_next;
    logic                       stage_load;

    assign stage_load = (state_reg == ST_READ) && pf_active_reg && (!m_valid || m_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pf_ptr_reg    <= '0;
            pf_active_reg <= 1'b0;
        end else begin
            pf_ptr_reg    <= pf_ptr_next;
            pf_active_reg <= pf_active_next;
        end
    end

    always_comb begin
        pf_ptr_next    = pf_ptr_reg;
        pf_active_next = pf_active_reg;
        if ((state_reg == ST_FULL) && !load_start && rd_start) begin
            pf_ptr_next    = '0;
            pf_active_next = 1'b1;
        end else if (stage_load) begin
            if (pf_ptr_reg == LAST_ADDR) begin
                pf_active_next = 1'b0;
            end else begin
                pf_ptr_next = pf_ptr_reg + ONE;
            end
        end
    end

    assign bram_rd_addr = pf_ptr_reg;

    bram_out_stage #(
        .WIDTH(WEIGHT_WIDTH)
    ) u_out_stage (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (stage_load),
        .in_data  (bram_rd_data),
        .in_last  (pf_ptr_reg == LAST_ADDR),
        .out_ready(m_ready),
        .out_valid(m_valid),
        .out_data (m_data),
        .out_last (m_last)
    );
`else
    assign bram_rd_addr = rd_ptr_reg;
    assign m_valid      = (state_reg == ST_READ);
    assign m_data       = bram_rd_data;
    assign m_last       = m_valid && rd_last;
`endif

endmodule
